// File: rtl/ahb_arbiter2_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter2_if
// Description : Bundle of every bus signal around the two-master AHB-Lite
//               arbiter: the two master-side address/data ports, the muxed
//               address phase to the decoder, and the read/ready/response
//               return from ahb_mux.
//   modport slave  : arbiter view (takes master requests, drives the bus)
//   modport master : environment view (masters, decoder and ahb_mux)
// Revision    : 1.0  initial release
// ============================================================================
interface ahb_arbiter2_if;
    // master 0
    logic [31:0] M0_HADDR_I;
    logic [1:0]  M0_HTRANS_I;
    logic        M0_HWRITE_I;
    logic [2:0]  M0_HSIZE_I;
    logic [2:0]  M0_HBURST_I;
    logic [3:0]  M0_HPROT_I;
    logic        M0_HMASTLOCK_I;
    logic [31:0] M0_HWDATA_I;
    logic [31:0] M0_HRDATA_O;
    logic        M0_HREADY_O;
    logic        M0_HRESP_O;
    // master 1
    logic [31:0] M1_HADDR_I;
    logic [1:0]  M1_HTRANS_I;
    logic        M1_HWRITE_I;
    logic [2:0]  M1_HSIZE_I;
    logic [2:0]  M1_HBURST_I;
    logic [3:0]  M1_HPROT_I;
    logic        M1_HMASTLOCK_I;
    logic [31:0] M1_HWDATA_I;
    logic [31:0] M1_HRDATA_O;
    logic        M1_HREADY_O;
    logic        M1_HRESP_O;
    // shared bus
    logic [31:0] HADDR_O;
    logic [1:0]  HTRANS_O;
    logic        HWRITE_O;
    logic [2:0]  HSIZE_O;
    logic [2:0]  HBURST_O;
    logic [3:0]  HPROT_O;
    logic        HMASTLOCK_O;
    logic [31:0] HWDATA_O;
    logic [31:0] HRDATA_I;
    logic        HREADY_I;
    logic        HRESP_I;
    logic        HMASTER_O;
    logic        STARVE_O;

    modport slave (
        input  M0_HADDR_I, M0_HTRANS_I, M0_HWRITE_I, M0_HSIZE_I, M0_HBURST_I,
               M0_HPROT_I, M0_HMASTLOCK_I, M0_HWDATA_I,
        output M0_HRDATA_O, M0_HREADY_O, M0_HRESP_O,
        input  M1_HADDR_I, M1_HTRANS_I, M1_HWRITE_I, M1_HSIZE_I, M1_HBURST_I,
               M1_HPROT_I, M1_HMASTLOCK_I, M1_HWDATA_I,
        output M1_HRDATA_O, M1_HREADY_O, M1_HRESP_O,
        output HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O,
               HMASTLOCK_O, HWDATA_O, HMASTER_O, STARVE_O,
        input  HRDATA_I, HREADY_I, HRESP_I
    );

    modport master (
        output M0_HADDR_I, M0_HTRANS_I, M0_HWRITE_I, M0_HSIZE_I, M0_HBURST_I,
               M0_HPROT_I, M0_HMASTLOCK_I, M0_HWDATA_I,
        input  M0_HRDATA_O, M0_HREADY_O, M0_HRESP_O,
        output M1_HADDR_I, M1_HTRANS_I, M1_HWRITE_I, M1_HSIZE_I, M1_HBURST_I,
               M1_HPROT_I, M1_HMASTLOCK_I, M1_HWDATA_I,
        input  M1_HRDATA_O, M1_HREADY_O, M1_HRESP_O,
        input  HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O,
               HMASTLOCK_O, HWDATA_O, HMASTER_O, STARVE_O,
        output HRDATA_I, HREADY_I, HRESP_I
    );
endinterface
`default_nettype wire

// File: rtl/ahb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter2
// Description : Two-master AHB-Lite arbiter (master 0 = CPU, master 1 = e.g.
//               DMA). Muxes the granted master's address phase onto the bus,
//               steers write data by data-phase owner, stalls the waiting
//               master with HREADY low and raises a sticky starvation flag.
//   HCLK_I   : bus clock, rising edge
//   HRESET_I : synchronous active-high reset
//   bus      : ahb_arbiter2_if.slave (master ports, shared bus, status)
//   MAX_WAIT : stalled-request cycles of the non-owner before STARVE_O
//   CW       : wait counter width, 2**CW > MAX_WAIT
// Revision    : 1.0  initial release
// ============================================================================
module ahb_arbiter2 #(
    parameter int MAX_WAIT = 256,
    parameter int CW       = 9
) (
    input  wire logic    HCLK_I,
    input  wire logic    HRESET_I,
    ahb_arbiter2_if.slave bus
);

    localparam logic [CW-1:0] c_max_wait = CW'(MAX_WAIT);
    localparam logic [1:0]    c_idle     = 2'b00;

    typedef enum logic [0:0] {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_t;

    grant_t        r_grant;
    grant_t        w_grant_nxt;
    logic          r_data_owner;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic          r_starve;

    logic          w_m0_req;
    logic          w_m1_req;
    logic          w_own_idle;
    logic          w_own_lock;
    logic          w_oth_req;
    logic          w_switch;

    // NONSEQ/SEQ carry HTRANS[1]=1; IDLE and BUSY are not requests.
    assign w_m0_req = bus.M0_HTRANS_I[1];
    assign w_m1_req = bus.M1_HTRANS_I[1];

    // ------------------------------------------------------------------
    // Grant state register
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK_I) begin
        if (HRESET_I) begin
            r_grant      <= GNT_M0;
            r_data_owner <= 1'b0;
            r_wait_cnt   <= '0;
            r_starve     <= 1'b0;
        end else begin
            r_grant    <= w_grant_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (bus.HREADY_I) begin
                r_data_owner <= r_grant;
            end
            if (w_wait_cnt_nxt == c_max_wait) begin
                r_starve <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next grant and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        w_own_idle     = 1'b0;
        w_own_lock     = 1'b0;
        w_oth_req      = 1'b0;
        w_switch       = 1'b0;
        w_grant_nxt    = r_grant;
        w_wait_cnt_nxt = r_wait_cnt;

        if (r_grant == GNT_M0) begin
            w_own_idle = (bus.M0_HTRANS_I == c_idle);
            w_own_lock = bus.M0_HMASTLOCK_I;
            w_oth_req  = w_m1_req;
        end else begin
            w_own_idle = (bus.M1_HTRANS_I == c_idle);
            w_own_lock = bus.M1_HMASTLOCK_I;
            w_oth_req  = w_m0_req;
        end

        // Hand-over only at a transfer boundary of an idle, unlocked owner;
        // with both requesting the other side wins, giving 2-way round-robin.
        w_switch = bus.HREADY_I & w_own_idle & ~w_own_lock & w_oth_req;

        case (r_grant)
            GNT_M0:  w_grant_nxt = w_switch ? GNT_M1 : GNT_M0;
            GNT_M1:  w_grant_nxt = w_switch ? GNT_M0 : GNT_M1;
            default: w_grant_nxt = GNT_M0;
        endcase

        if (w_switch || !w_oth_req) begin
            w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt != c_max_wait) begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Address-phase mux, write-data steering, ready/response return
    // ------------------------------------------------------------------
    always_comb begin
        bus.HADDR_O     = bus.M0_HADDR_I;
        bus.HTRANS_O    = bus.M0_HTRANS_I;
        bus.HWRITE_O    = bus.M0_HWRITE_I;
        bus.HSIZE_O     = bus.M0_HSIZE_I;
        bus.HBURST_O    = bus.M0_HBURST_I;
        bus.HPROT_O     = bus.M0_HPROT_I;
        bus.HMASTLOCK_O = bus.M0_HMASTLOCK_I;
        if (r_grant == GNT_M1) begin
            bus.HADDR_O     = bus.M1_HADDR_I;
            bus.HTRANS_O    = bus.M1_HTRANS_I;
            bus.HWRITE_O    = bus.M1_HWRITE_I;
            bus.HSIZE_O     = bus.M1_HSIZE_I;
            bus.HBURST_O    = bus.M1_HBURST_I;
            bus.HPROT_O     = bus.M1_HPROT_I;
            bus.HMASTLOCK_O = bus.M1_HMASTLOCK_I;
        end
    end

    // Write data belongs to whoever owned the previous accepted address phase.
    assign bus.HWDATA_O  = r_data_owner ? bus.M1_HWDATA_I : bus.M0_HWDATA_I;
    assign bus.HMASTER_O = r_grant;
    assign bus.STARVE_O  = r_starve;

    assign bus.M0_HRDATA_O = bus.HRDATA_I;
    assign bus.M1_HRDATA_O = bus.HRDATA_I;
    assign bus.M0_HRESP_O  = bus.HRESP_I;
    assign bus.M1_HRESP_O  = bus.HRESP_I;

    // A non-owner is frozen while it requests so its address phase stays
    // stable until the grant arrives and is then presented untouched.
    assign bus.M0_HREADY_O = (r_grant == GNT_M0) ? bus.HREADY_I : ~w_m0_req;
    assign bus.M1_HREADY_O = (r_grant == GNT_M1) ? bus.HREADY_I : ~w_m1_req;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_arbiter2
// Description : Directed scoreboard bench for ahb_arbiter2 (MAX_WAIT=4).
//               Stimulus pushes tagged expectations; a negedge monitor pops
//               and compares them in the cycle they are due.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_arbiter2;

    localparam int ID_HMASTER  = 0;
    localparam int ID_HADDR    = 1;
    localparam int ID_HWDATA   = 2;
    localparam int ID_M0_RDY   = 3;
    localparam int ID_M1_RDY   = 4;
    localparam int ID_STARVE   = 5;
    localparam int ID_MLOCK    = 6;
    localparam int ID_M1_RDATA = 7;
    localparam int ID_M0_RESP  = 8;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t sb[$];
    logic [31:0] act;

    ahb_arbiter2_if bus();

    ahb_arbiter2 #(.MAX_WAIT(4), .CW(3)) dut (
        .HCLK_I   (clk),
        .HRESET_I (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic string sig_name(int id);
        case (id)
            ID_HMASTER:  return "HMASTER_O";
            ID_HADDR:    return "HADDR_O";
            ID_HWDATA:   return "HWDATA_O";
            ID_M0_RDY:   return "M0_HREADY_O";
            ID_M1_RDY:   return "M1_HREADY_O";
            ID_STARVE:   return "STARVE_O";
            ID_MLOCK:    return "HMASTLOCK_O";
            ID_M1_RDATA: return "M1_HRDATA_O";
            default:     return "M0_HRESP_O";
        endcase
    endfunction

    function automatic logic [31:0] actual(int id);
        case (id)
            ID_HMASTER:  return {31'd0, bus.HMASTER_O};
            ID_HADDR:    return bus.HADDR_O;
            ID_HWDATA:   return bus.HWDATA_O;
            ID_M0_RDY:   return {31'd0, bus.M0_HREADY_O};
            ID_M1_RDY:   return {31'd0, bus.M1_HREADY_O};
            ID_STARVE:   return {31'd0, bus.STARVE_O};
            ID_MLOCK:    return {31'd0, bus.HMASTLOCK_O};
            ID_M1_RDATA: return bus.M1_HRDATA_O;
            default:     return {31'd0, bus.M0_HRESP_O};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_vec++;
                act = actual(sb[i].id);
                if (sb[i].cyc < cyc) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=unsampled expected=%h",
                             sig_name(sb[i].id), sb[i].cyc, sb[i].val);
                end else if (act !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h",
                             sig_name(sb[i].id), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int dcyc, input int id, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + dcyc;
        e.id  = id;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m0(input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic lk, input logic [31:0] wd);
        bus.M0_HTRANS_I    = tr;
        bus.M0_HADDR_I     = a;
        bus.M0_HWRITE_I    = wr;
        bus.M0_HMASTLOCK_I = lk;
        bus.M0_HWDATA_I    = wd;
    endtask

    task automatic m1(input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic lk, input logic [31:0] wd);
        bus.M1_HTRANS_I    = tr;
        bus.M1_HADDR_I     = a;
        bus.M1_HWRITE_I    = wr;
        bus.M1_HMASTLOCK_I = lk;
        bus.M1_HWDATA_I    = wd;
    endtask

    task automatic do_reset();
        m0(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.HREADY_I = 1'b1;
        bus.HRESP_I  = 1'b0;
        bus.HRDATA_I = 32'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.M0_HSIZE_I  = 3'd2;  bus.M1_HSIZE_I  = 3'd2;
        bus.M0_HBURST_I = 3'd0;  bus.M1_HBURST_I = 3'd0;
        bus.M0_HPROT_I  = 4'h3;  bus.M1_HPROT_I  = 4'h3;
        #1;
        step();

        // 1: reset with both masters idle
        do_reset();
        expect_at(0, ID_HMASTER, 0);
        expect_at(0, ID_M0_RDY, 1);
        expect_at(0, ID_M1_RDY, 1);
        expect_at(0, ID_STARVE, 0);
        step();

        // 2: M1 write while M0 idle, plus read/response broadcast
        do_reset();
        m1(NONSEQ, 32'h0001_0010, 1'b1, 1'b0, 32'h0);
        expect_at(0, ID_HMASTER, 0);
        expect_at(0, ID_M1_RDY, 0);
        expect_at(0, ID_M0_RDY, 1);
        expect_at(1, ID_HMASTER, 1);
        expect_at(1, ID_HADDR, 32'h0001_0010);
        expect_at(1, ID_M1_RDY, 1);
        expect_at(1, ID_M0_RDY, 1);
        step();
        step();
        m1(IDLE, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        bus.HRDATA_I = 32'h1234_5678;
        bus.HRESP_I  = 1'b1;
        expect_at(0, ID_HWDATA, 32'hDEAD_BEEF);
        expect_at(0, ID_M1_RDATA, 32'h1234_5678);
        expect_at(0, ID_M0_RESP, 1);
        expect_at(0, ID_M0_RDY, 1);
        step();
        bus.HRESP_I = 1'b0;

        // 3: M0 back-to-back NONSEQ holds off M1
        do_reset();
        m1(NONSEQ, 32'h0002_0000, 1'b0, 1'b0, 32'h0);
        m0(NONSEQ, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        expect_at(0, ID_HMASTER, 0);
        expect_at(0, ID_M1_RDY, 0);
        expect_at(0, ID_HADDR, 32'h0000_0100);
        step();
        m0(NONSEQ, 32'h0000_0104, 1'b0, 1'b0, 32'h0);
        expect_at(0, ID_HMASTER, 0);
        expect_at(0, ID_HADDR, 32'h0000_0104);
        step();
        m0(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_at(0, ID_M1_RDY, 0);
        expect_at(1, ID_HMASTER, 1);
        expect_at(1, ID_HADDR, 32'h0002_0000);
        expect_at(1, ID_M1_RDY, 1);
        step();
        step();
        m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);

        // 4: three wait states on M0's write while M1 requests
        do_reset();
        m1(NONSEQ, 32'h0003_0000, 1'b0, 1'b0, 32'h0);
        m0(NONSEQ, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
        step();
        m0(IDLE, 32'h0, 1'b0, 1'b0, 32'hCAFE_0001);
        bus.HREADY_I = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_at(0, ID_HMASTER, 0);
            expect_at(0, ID_M0_RDY, 0);
            expect_at(0, ID_M1_RDY, 0);
            expect_at(0, ID_HWDATA, 32'hCAFE_0001);
            step();
        end
        bus.HREADY_I = 1'b1;
        expect_at(0, ID_HMASTER, 0);
        expect_at(0, ID_M0_RDY, 1);
        expect_at(0, ID_HWDATA, 32'hCAFE_0001);
        expect_at(1, ID_HMASTER, 1);
        expect_at(1, ID_HADDR, 32'h0003_0000);
        step();
        step();
        m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);

        // 5: locked sequence with IDLE gaps blocks hand-over
        do_reset();
        m1(NONSEQ, 32'h0004_0000, 1'b0, 1'b0, 32'h0);
        m0(NONSEQ, 32'h0000_0300, 1'b1, 1'b1, 32'h0);
        step();
        m0(IDLE, 32'h0, 1'b0, 1'b1, 32'h0);
        expect_at(0, ID_HMASTER, 0);
        expect_at(0, ID_MLOCK, 1);
        expect_at(0, ID_M1_RDY, 0);
        step();
        m0(NONSEQ, 32'h0000_0304, 1'b1, 1'b1, 32'h0);
        expect_at(0, ID_HMASTER, 0);
        step();
        m0(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_at(0, ID_HMASTER, 0);
        expect_at(0, ID_M1_RDY, 0);
        expect_at(1, ID_HMASTER, 1);
        step();
        step();
        m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);

        // 6: starvation after 4 stalled cycles, sticky until reset
        do_reset();
        m1(NONSEQ, 32'h0005_0000, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            m0(NONSEQ, 32'h0000_0400 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            expect_at(0, ID_STARVE, (i >= 4) ? 32'd1 : 32'd0);
            expect_at(0, ID_HMASTER, 0);
            step();
        end
        m0(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_at(0, ID_STARVE, 1);
        expect_at(1, ID_HMASTER, 1);
        expect_at(1, ID_STARVE, 1);
        step();
        // reset while M1 owns the bus and keeps requesting
        rst = 1'b1;
        expect_at(1, ID_STARVE, 0);
        expect_at(1, ID_HMASTER, 0);
        expect_at(1, ID_M1_RDY, 0);
        step();
        rst = 1'b0;
        step();
        m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);

        // drain
        for (int i = 0; i < 4; i++) step();
        while (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s cyc=%0d got=unsampled expected=%h",
                     sig_name(sb[0].id), sb[0].cyc, sb[0].val);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_arbiter2.md
Name: ahb_arbiter2

Overview:
- Two-master AHB-Lite arbiter that shares the single system bus between the Cortex-M0 (master 0) and a second bus master (master 1, e.g. a DMA engine).
- Sits between the masters and the address decoder / ahb_mux.
- Muxes the granted master's address phase onto the bus and steers write data by data-phase owner.
- Stalls the waiting master with HREADY low and flags starvation.

Parameters:
MAX_WAIT, 256, consecutive stalled-request cycles of the non-owner before STARVE_O sets.
CW, 9, width of the wait counter; must satisfy 2^CW > MAX_WAIT.

Ports:
HCLK_I  in  1  bus clock; all logic on the rising edge.
HRESET_I  in  1  synchronous, active-high reset.
M0_HADDR_I  in  32  master 0 address.
M0_HTRANS_I  in  2  master 0 transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
M0_HWRITE_I  in  1  master 0 write.
M0_HSIZE_I  in  3  master 0 size.
M0_HBURST_I  in  3  master 0 burst.
M0_HPROT_I  in  4  master 0 protection.
M0_HMASTLOCK_I  in  1  master 0 locked sequence.
M0_HWDATA_I  in  32  master 0 write data.
M0_HRDATA_O  out  32  read data to master 0.
M0_HREADY_O  out  1  ready to master 0.
M0_HRESP_O  out  1  response to master 0.
M1_*  same set, widths and directions as M0_*, for master 1.
HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O, HMASTLOCK_O  out  32/2/1/3/3/4/1  muxed address phase to decoder and slaves.
HWDATA_O  out  32  muxed write data.
HRDATA_I  in  32  read data from ahb_mux.
HREADY_I  in  1  bus HREADY from ahb_mux.
HRESP_I  in  1  bus HRESP from ahb_mux.
HMASTER_O  out  1  current address-phase owner (grant).
STARVE_O  out  1  sticky starvation flag.

Behaviour:
- Interface decision: one clock HCLK_I; reset HRESET_I is synchronous and active-high.
- Reset values on the next edge with HRESET_I=1, regardless of bus state:
  - grant=0, data_owner=0, wait_cnt=0, STARVE_O=0.
  - Outputs then follow the combinational rules below with grant=0.
- Request definition: reqN = MN_HTRANS_I[1]. BUSY is not a request.
- Address mux: all address/control outputs are combinational copies of the grant master's inputs. HMASTER_O = grant.
- Data-phase owner: when HREADY_I=1, data_owner <= grant. HWDATA_O = data_owner's HWDATA.
- Read return: HRDATA_I and HRESP_I are broadcast to both masters unmodified.
- HREADY_O rules:
  - Owner (grant): HREADY_I.
  - Non-owner: 0 while it requests, else 1.
  - Hence a waiting master holds its address phase stable and the phase is presented untouched once granted.
- Grant switching: evaluated only on edges with HREADY_I=1. grant <= other when all of the following hold:
  - owner HTRANS=IDLE;
  - owner HMASTLOCK=0;
  - other master requests.
- Grant is held in every other case:
  - owner NONSEQ/SEQ/BUSY, or locked;
  - HREADY_I=0 (wait state);
  - neither master requests (bus parks on the last owner).
- Switch latency: the new owner's address phase appears on HADDR_O in the cycle after the switching edge. Minimum grant hand-over costs 1 cycle.
- Simultaneous requests with the owner idle: the other master wins (implicit 2-way round-robin).
- Starvation counter (wait_cnt):
  - Increments each cycle the non-owner requests.
  - Clears to 0 on a grant switch or when the non-owner drops its request.
  - Saturates at MAX_WAIT.
  - STARVE_O sets on the edge where wait_cnt reaches MAX_WAIT and stays 1 until reset.
- Error response: HRESP_I=1 is passed through. No grant change is forced; the switching rule still applies.
- Reset during an active transfer: the in-flight transfer is abandoned and grant returns to master 0. No pending state survives reset.

Test Plan:
1. Reset, both idle -> HMASTER_O=0, M0_HREADY_O=1, M1_HREADY_O=1, STARVE_O=0.
2. M1 NONSEQ write to 0x0001_0010 while M0 IDLE -> grant switches on the next edge. HADDR_O=0x0001_0010 one cycle later. M1_HWDATA_I appears on HWDATA_O in the data phase. M0 sees HREADY=1 throughout.
3. M0 issues back-to-back NONSEQ while M1 requests -> M1_HREADY_O=0 and grant stays 0. When M0 goes IDLE, grant moves to 1 and M1's held address is accepted.
4. Slave inserts 3 wait states (HREADY_I=0) during M0's transfer while M1 requests -> no switch during the wait states. M0_HREADY_O mirrors HREADY_I; HWDATA_O stays M0's data.
5. M0 holds HMASTLOCK=1 with IDLE between locked transfers while M1 requests -> no switch until HMASTLOCK=0.
6. MAX_WAIT=4, M0 streams NONSEQ for 10 cycles while M1 requests -> STARVE_O rises exactly 4 cycles after M1's request and stays 1 until HRESET_I=1.
